// File: rtl/dir_request_sequencer.sv
// MSI directory request sequencer: arbitrates GetS/GetM misses from two L1 caches and
// walks each transaction through lookup, remote invalidate/flush, memory access, directory update and response.
module dir_request_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [1:0]          Req,
  input  logic [1:0]          ReqWrite,
  input  logic [2*ADDR_W-1:0] ReqAddr,
  output logic [1:0]          Gnt,
  output logic [1:0]          Done,
  output logic [DATA_W-1:0]   RData,
  output logic [ADDR_W-1:0]   DirAddr,
  input  logic [2:0]          DirRdState,
  input  logic [1:0]          DirRdSharers,
  output logic                DirWe,
  output logic [2:0]          DirWrState,
  output logic [1:0]          DirWrSharers,
  output logic                MemRe,
  output logic                MemWe,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWData,
  input  logic [DATA_W-1:0]   MemRData,
  input  logic                MemAck,
  output logic [1:0]          InvReq,
  output logic                InvFlush,
  input  logic [1:0]          InvAck,
  input  logic [DATA_W-1:0]   InvData
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WAIT_ACK, MEM_RD, MEM_WB, UPDATE, RESP
  } seqState_t;

  seqState_t state, stateNext;

  logic              rrPtr;        // 0 = P0 wins the next contended grant
  logic              reqId;
  logic              reqWr;
  logic [ADDR_W-1:0] reqAddr;
  logic [1:0]        invMask;
  logic              invFlushQ;
  logic [1:0]        oldSharers;
  logic              oldValid;     // looked-up line was in S or M
  logic [DATA_W-1:0] lineData;     // data gathered during the transaction
  logic [DATA_W-1:0] rDataQ;       // data presented to the requester, changes only at RESP

  logic       grantId;
  logic [1:0] grantVec;
  logic [1:0] invNext;
  logic       flushNext;
  logic [1:0] reqBit, otherBit;
  logic       dirS, dirM;

  assign reqBit   = reqId ? 2'b10 : 2'b01;
  assign otherBit = ~reqBit;
  // Encodings 1xx fall through both compares and behave as I.
  assign dirS     = (DirRdState == 3'b010);
  assign dirM     = (DirRdState == 3'b011);

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    grantId   = 1'b0;
    grantVec  = 2'b00;
    invNext   = 2'b00;
    flushNext = 1'b0;
    case (state)
      IDLE: begin
        if (Req != 2'b00) begin
          grantId   = (Req == 2'b11) ? rrPtr : Req[1];
          grantVec  = grantId ? 2'b10 : 2'b01;
          stateNext = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!reqWr) begin
          if (dirM && (DirRdSharers & otherBit) != 2'b00) begin
            invNext   = otherBit;
            flushNext = 1'b1;
            stateNext = WAIT_ACK;
          end else if (dirM && (DirRdSharers & reqBit) != 2'b00) begin
            stateNext = RESP;
          end else begin
            stateNext = MEM_RD;
          end
        end else if ((dirM || dirS) && (DirRdSharers & otherBit) != 2'b00) begin
          invNext   = otherBit;
          flushNext = dirM;
          stateNext = WAIT_ACK;
        end else begin
          stateNext = UPDATE;
        end
      end
      WAIT_ACK: begin
        if ((invMask & ~InvAck) == 2'b00) stateNext = reqWr ? UPDATE : MEM_WB;
      end
      MEM_RD, MEM_WB: begin
        if (MemAck) stateNext = UPDATE;
      end
      UPDATE:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state      <= IDLE;
      rrPtr      <= 1'b0;
      reqId      <= 1'b0;
      reqWr      <= 1'b0;
      reqAddr    <= '0;
      invMask    <= 2'b00;
      invFlushQ  <= 1'b0;
      oldSharers <= 2'b00;
      oldValid   <= 1'b0;
      lineData   <= '0;
      rDataQ     <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (stateNext == LOOKUP) begin
            reqId   <= grantId;
            reqWr   <= ReqWrite[grantId];
            reqAddr <= grantId ? ReqAddr[2*ADDR_W-1:ADDR_W] : ReqAddr[ADDR_W-1:0];
            if (Req == 2'b11) rrPtr <= ~grantId;
          end
        end
        LOOKUP: begin
          invMask    <= invNext;
          invFlushQ  <= flushNext;
          oldSharers <= DirRdSharers;
          oldValid   <= dirS || dirM;
          if (reqWr || stateNext == RESP) lineData <= '0;
        end
        WAIT_ACK: begin
          invMask <= invMask & ~InvAck;
          // The flushing owner's data goes to memory (GetS) or straight to the new owner (GetM).
          if (invFlushQ && (InvAck & invMask) != 2'b00) lineData <= InvData;
        end
        MEM_RD: begin
          if (MemAck) lineData <= MemRData;
        end
        default: ;
      endcase
      if (stateNext == RESP) rDataQ <= (state == LOOKUP) ? '0 : lineData;
    end
  end

  assign Gnt          = ResetN ? grantVec : 2'b00;
  assign Done         = (state == RESP) ? reqBit : 2'b00;
  assign RData        = rDataQ;
  assign DirAddr      = reqAddr;
  assign DirWe        = (state == UPDATE);
  assign DirWrState   = DirWe ? (reqWr ? 3'b011 : 3'b010) : 3'b000;
  assign DirWrSharers = !DirWe ? 2'b00 :
                        (reqWr || !oldValid) ? reqBit : (oldSharers | reqBit);
  assign MemRe        = (state == MEM_RD);
  assign MemWe        = (state == MEM_WB);
  assign MemAddr      = (MemRe || MemWe) ? reqAddr : '0;
  assign MemWData     = MemWe ? lineData : '0;
  assign InvReq       = invMask;
  assign InvFlush     = invFlushQ && (invMask != 2'b00);

endmodule

// File: tb/tb_dir_request_sequencer.sv
// Self-checking bench for dir_request_sequencer: directed protocol cases, then randomized
// two-requester traffic checked against a rule-level MSI transaction model.
module tb_dir_request_sequencer;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic [1:0] Req, ReqWrite;
  logic [7:0] ReqAddr;
  logic [1:0] Gnt, Done;
  logic [3:0] RData, DirAddr;
  logic [2:0] DirRdState, DirWrState;
  logic [1:0] DirRdSharers, DirWrSharers;
  logic       DirWe, MemRe, MemWe, MemAck, InvFlush;
  logic [3:0] MemAddr, MemWData, MemRData, InvData;
  logic [1:0] InvReq, InvAck;

  logic [2:0] dirSt [16];
  logic [1:0] dirSh [16];
  assign DirRdState   = dirSt[DirAddr];
  assign DirRdSharers = dirSh[DirAddr];

  dir_request_sequencer #(.ADDR_W(4), .DATA_W(4)) dut (
    .Clock(Clock), .ResetN(ResetN), .Req(Req), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr),
    .Gnt(Gnt), .Done(Done), .RData(RData), .DirAddr(DirAddr),
    .DirRdState(DirRdState), .DirRdSharers(DirRdSharers), .DirWe(DirWe),
    .DirWrState(DirWrState), .DirWrSharers(DirWrSharers), .MemRe(MemRe), .MemWe(MemWe),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .InvReq(InvReq), .InvFlush(InvFlush), .InvAck(InvAck), .InvData(InvData)
  );

  always #5 Clock = ~Clock;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  logic       rrModel;
  logic [3:0] lastRData;
  logic [2:0] lastDwSt;
  logic [1:0] lastDwSh, lastInv;
  logic [3:0] lastWbAddr, lastWbData;
  logic       lastFlush;

  // Expected transaction outcome; src: 0 = zero data, 1 = memory data, 2 = flushed data.
  typedef struct packed {
    logic [1:0] inv;
    logic       flush;
    logic       memRd;
    logic       memWb;
    logic       dirWe;
    logic [2:0] st;
    logic [1:0] sh;
    logic [1:0] src;
  } expT;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic expT model(input logic w, input logic id, input logic [2:0] st, input logic [1:0] sh);
    expT e;
    logic [1:0] me, peer;
    logic isM, isS;
    e    = '0;
    me   = id ? 2'b10 : 2'b01;
    peer = id ? 2'b01 : 2'b10;
    isM  = (st == 3'd3);
    isS  = (st == 3'd2);
    if (!w) begin
      if (isM && (sh & peer) != 0) begin
        e.inv = peer; e.flush = 1; e.memWb = 1; e.dirWe = 1; e.st = 3'd2; e.sh = sh | me; e.src = 2;
      end else if (isM && (sh & me) != 0) begin
        e.src = 0;
      end else begin
        e.memRd = 1; e.dirWe = 1; e.st = 3'd2; e.sh = isS ? (sh | me) : me; e.src = 1;
      end
    end else begin
      if ((isM || isS) && (sh & peer) != 0) begin
        e.inv = peer; e.flush = isM; e.src = isM ? 2'd2 : 2'd0;
      end
      e.dirWe = 1; e.st = 3'd3; e.sh = me;
    end
    return e;
  endfunction

  // Presents a request pattern in an IDLE cycle and runs the granted transaction to Done.
  task automatic runTxn(input logic [1:0] reqMask, input logic [1:0] wrVec, input logic [7:0] addrVec,
                        input bit holdReq, input int memDelay, input int invDelay,
                        input logic [3:0] memVal, input logic [3:0] flushVal, output logic gid);
    expT e;
    logic w;
    logic [3:0] a, expData;
    logic [1:0] gbit, invObs, doneObs;
    logic flushObs, invAcked, mAcked, invLate, memLate, rdSeen, wbSeen;
    logic [3:0] rdAddr, wbAddr, wbData, rdObs;
    logic [2:0] dwSt;
    logic [1:0] dwSh;
    int invCnt, memCnt, dwCnt, dwCyc, doneCyc, gntBusy, expLat;
    invObs = 0; flushObs = 0; invAcked = 0; mAcked = 0; invLate = 0; memLate = 0;
    rdSeen = 0; wbSeen = 0; rdAddr = 0; wbAddr = 0; wbData = 0; rdObs = 0; doneObs = 0;
    dwSt = 0; dwSh = 0; invCnt = 0; memCnt = 0; dwCnt = 0; dwCyc = 0; doneCyc = 0; gntBusy = 0;

    check("rdata_hold", RData, lastRData);
    Req = reqMask; ReqWrite = wrVec; ReqAddr = addrVec;
    #1;
    gid = (reqMask == 2'b11) ? rrModel : reqMask[1];
    if (reqMask == 2'b11) rrModel = ~gid;
    gbit = gid ? 2'b10 : 2'b01;
    check("gnt", Gnt, gbit);
    w = wrVec[gid];
    a = gid ? addrVec[7:4] : addrVec[3:0];
    e = model(w, gid, dirSt[a], dirSh[a]);
    expData = (e.src == 1) ? memVal : (e.src == 2) ? flushVal : 4'h0;
    if (e.inv != 0)  expLat = w ? 4 + invDelay : 5 + invDelay + memDelay;
    else if (e.memRd) expLat = 4 + memDelay;
    else if (e.dirWe) expLat = 3;
    else              expLat = 2;

    for (int cyc = 1; cyc <= 80; cyc++) begin
      step();
      if (cyc == 1) Req = holdReq ? reqMask : (reqMask & ~gbit);
      MemAck = 0;
      InvAck = 0;
      if (Gnt != 0) gntBusy++;
      if (InvReq != 0) begin
        if (invCnt == 0) begin invObs = InvReq; flushObs = InvFlush; end
        if (invAcked) invLate = 1;
        invCnt++;
        if (invCnt == invDelay + 1) begin InvAck = InvReq; InvData = flushVal; invAcked = 1; end
      end
      if (MemRe || MemWe) begin
        if (MemRe) begin rdSeen = 1; rdAddr = MemAddr; end
        if (MemWe) begin wbSeen = 1; wbAddr = MemAddr; wbData = MemWData; end
        if (mAcked) memLate = 1;
        memCnt++;
        if (memCnt == memDelay + 1) begin MemAck = 1; MemRData = memVal; mAcked = 1; end
      end
      if (DirWe) begin dwCnt++; dwSt = DirWrState; dwSh = DirWrSharers; dwCyc = cyc; end
      if (Done != 0) begin doneObs = Done; rdObs = RData; doneCyc = cyc; break; end
    end
    MemAck = 0;
    InvAck = 0;

    check("done_seen", doneCyc != 0, 1);
    check("gnt_while_busy", gntBusy, 0);
    check("inv_target", invObs, e.inv);
    if (e.inv != 0) check("inv_flush", flushObs, e.flush);
    check("inv_drop", invLate, 0);
    check("mem_read", rdSeen, e.memRd);
    if (e.memRd) check("mem_read_addr", rdAddr, a);
    check("mem_wb", wbSeen, e.memWb);
    if (e.memWb) begin
      check("mem_wb_addr", wbAddr, a);
      check("mem_wb_data", wbData, flushVal);
    end
    check("mem_drop", memLate, 0);
    check("dir_we_count", dwCnt, e.dirWe);
    if (e.dirWe) begin
      check("dir_wr_state", dwSt, e.st);
      check("dir_wr_sharers", dwSh, e.sh);
      check("dir_we_cycle", dwCyc, expLat - 1);
      dirSt[a] = e.st;
      dirSh[a] = e.sh;
    end
    check("done_id", doneObs, gbit);
    check("rdata", rdObs, expData);
    check("latency", doneCyc, expLat);
    lastRData = rdObs; lastDwSt = dwSt; lastDwSh = dwSh; lastInv = invObs;
    lastFlush = flushObs; lastWbAddr = wbAddr; lastWbData = wbData;
  endtask

  initial begin : main
    logic g;
    logic [1:0] pend, pWr;
    logic [3:0] pAddr [2];
    int ids [3];

    for (int i = 0; i < 16; i++) begin dirSt[i] = 0; dirSh[i] = 0; end
    ResetN = 0; Req = 2'b11; ReqWrite = 0; ReqAddr = 0;
    MemAck = 0; MemRData = 0; InvAck = 0; InvData = 0;
    rrModel = 0; lastRData = 0;

    // Reset held two cycles with both requests up: no grant, all outputs quiet.
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_gnt", Gnt, 2'b00);
      check("reset_outputs", {Gnt, Done, RData, DirWe, DirWrState, DirWrSharers, MemRe, MemWe,
                              MemAddr, MemWData, InvReq, InvFlush, DirAddr}, 0);
    end
    ResetN = 1;

    // Contended GetM stream to empty lines: P0 first, then alternating.
    for (int i = 0; i < 3; i++) begin
      runTxn(2'b11, 2'b11, 8'h54, 1, 0, 0, 4'h0, 4'h0, g);
      ids[i] = g;
      step();
    end
    Req = 0;
    check("rr_order", {ids[0][0], ids[1][0], ids[2][0]}, 3'b010);

    // P0 GetS on an I line, memory answers two cycles after MemRe.
    dirSt[3] = 3'b001; dirSh[3] = 2'b00;
    runTxn(2'b01, 2'b00, 8'h03, 0, 2, 0, 4'b0101, 4'h0, g);
    check("t3_rdata", lastRData, 4'b0101);
    check("t3_dir", {lastDwSt, lastDwSh}, {3'b010, 2'b01});
    step();

    // P1 GetM on a line shared by both: invalidate P0 without flush.
    dirSt[1] = 3'b010; dirSh[1] = 2'b11;
    runTxn(2'b10, 2'b10, 8'h10, 0, 0, 0, 4'h0, 4'h0, g);
    check("t4_inv", {lastInv, lastFlush}, {2'b01, 1'b0});
    check("t4_dir", {lastDwSt, lastDwSh}, {3'b011, 2'b10});
    check("t4_rdata", lastRData, 4'b0000);
    step();

    // P0 GetS on a line modified by P1: flush, write back, both become sharers.
    dirSt[2] = 3'b011; dirSh[2] = 2'b10;
    runTxn(2'b01, 2'b00, 8'h02, 0, 1, 1, 4'h0, 4'b1000, g);
    check("t5_inv", {lastInv, lastFlush}, {2'b10, 1'b1});
    check("t5_wb", {lastWbAddr, lastWbData}, {4'b0010, 4'b1000});
    check("t5_dir", {lastDwSt, lastDwSh}, {3'b010, 2'b11});
    check("t5_rdata", lastRData, 4'b1000);
    step();

    // Redundant GetS by the current owner: no directory write, zero data.
    dirSt[9] = 3'b011; dirSh[9] = 2'b01;
    runTxn(2'b01, 2'b00, 8'h09, 0, 0, 0, 4'h0, 4'h0, g);
    step();

    // Reset while waiting for an invalidate ack abandons the transaction.
    dirSt[6] = 3'b011; dirSh[6] = 2'b01;
    Req = 2'b10; ReqWrite = 2'b00; ReqAddr = 8'h60;
    #1;
    check("t6_gnt", Gnt, 2'b10);
    step();
    Req = 0;
    step();
    check("t6_inv_wait", {InvReq, InvFlush}, {2'b01, 1'b1});
    ResetN = 0;
    step();
    check("t6_after_reset", {InvReq, InvFlush, DirWe, Done, RData}, 0);
    ResetN = 1; rrModel = 0; lastRData = 0;
    InvAck = 2'b01; InvData = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      InvAck = 0;
      check("t6_stray_ack", {InvReq, DirWe, Done, Gnt, MemRe, MemWe}, 0);
    end
    runTxn(2'b10, 2'b00, 8'h60, 0, 0, 2, 4'h0, 4'hA, g);
    step();

    // Randomized traffic from both requesters over a randomized directory.
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 4))
        0: begin dirSt[i] = 3'b000; dirSh[i] = 2'b00; end
        1: begin dirSt[i] = 3'b001; dirSh[i] = 2'($urandom); end
        2: begin dirSt[i] = 3'b010; dirSh[i] = 2'($urandom_range(1, 3)); end
        3: begin dirSt[i] = 3'b011; dirSh[i] = $urandom_range(0, 1) ? 2'b10 : 2'b01; end
        default: begin dirSt[i] = 3'($urandom_range(4, 7)); dirSh[i] = 2'($urandom); end
      endcase
    end
    pend = 0; pWr = 0; pAddr[0] = 0; pAddr[1] = 0;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1; pWr[i] = 1'($urandom); pAddr[i] = 4'($urandom);
        end
      end
      if (pend == 0) begin
        pend[0] = 1; pWr[0] = 1'($urandom); pAddr[0] = 4'($urandom);
      end
      runTxn(pend, pWr, {pAddr[1], pAddr[0]}, 0, $urandom_range(0, 3), $urandom_range(0, 3),
             4'($urandom), 4'($urandom), g);
      pend[g] = 0;
      step();
    end
    Req = 0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
